ca_line_renderer: RTL and testbench
===================================

// Module: ca_line_renderer
// PURPOSE
//  Pixel source sitting directly downstream of the VGA sync generator. Consumes its prefetch column, line
//  counter and prefetch-area flag. Renders a 1-D elementary cellular automaton: one generation per cell-row,
//  evolving down the screen. Emits registered 8-bit RGB aligned to the visible area. Reseeds each vertical blank.
// PARAMETERS
//  H_VISIBLE     1280    visible pixels per line (prefetch columns 0..H_VISIBLE-1)
//  V_VISIBLE     1024    visible lines; counter_y >= V_VISIBLE is vertical blank
//  CELL_SHIFT    2       cell = 2^CELL_SHIFT x 2^CELL_SHIFT pixels; NCELLS = H_VISIBLE>>CELL_SHIFT (320)
//  LEAD          16      cycles from prefetch column x presented to vga_rgb for x valid (>=2)
//  FG_COLOR      8'hFC   RGB332 colour for live cell
//  BG_COLOR      8'h00   RGB332 colour for dead cell (also blanking value is 8'h00, not BG)
// PORTS
//  clk           in   1   pixel clock
//  rst           in   1   synchronous reset, active-high
//  in_prefetch   in   1   high while prefetch_x in 0..H_VISIBLE-1 on a visible line
//  prefetch_x    in   11  prefetch column, increments every clk
//  counter_y     in   11  current line; advances once per line, wraps to 0 at frame end
//  rule          in   8   Wolfram rule number; sampled on SEED entry only
//  seed_mode     in   1   0 = single live cell at NCELLS/2; 1 = LFSR random row
//  freeze        in   1   1 = hold current generation (no commit, no reseed)
//  vga_rgb       out  8   RGB332 pixel, 0 outside visible area
//  gen_count     out  16  generations committed since last seed
// BEHAVIOUR
//  Reset: state=SEED, seed_idx=0, cur=0, nxt=0, rule_q=8'd30, lfsr=16'hACE1, gen_count=0, vga_rgb=0, pipes=0.
//  Storage: cur[NCELLS-1:0] displayed generation, nxt[NCELLS-1:0] generation under construction (flop vectors).
//  Render: each clk with in_prefetch=1: c = prefetch_x>>CELL_SHIFT; bit = cur[c] pushed into pixel pipe.
//   When also prefetch_x[CELL_SHIFT-1:0]==0: nxt[c] <= rule_q[{cur[c-1],cur[c],cur[c+1]}] (left=MSB).
//   Neighbours wrap: c-1 of 0 is NCELLS-1; c+1 of NCELLS-1 is 0.
//  Pipeline: pix pipe and vis pipe (in_prefetch), LEAD-1 flops each, followed by the output register.
//   vga_rgb <= vis_d ? (pix_d ? FG_COLOR : BG_COLOR) : 8'h00. Column x appears exactly LEAD clks after
//   the clk presenting x; vis_d gives blanking, so edge columns are never cut off and never leak.
//  Line end: detected as in_prefetch 1->0 (registered previous value).
//   If counter_y[CELL_SHIFT-1:0] all ones, state=RENDER and freeze=0: cur <= nxt, gen_count <= gen_count+1.
//   gen_count saturates at 16'hFFFF.
//  FSM:
//   RENDER -> SEED when counter_y==V_VISIBLE and freeze=0 (first blank line); latch rule_q<=rule, seed_idx<=0.
//   RENDER -> WAIT instead if freeze=1.
//   SEED: one cell per clk: cur[seed_idx] <= seed_mode ? lfsr[0] : (seed_idx==NCELLS/2);
//    after seed_idx==NCELLS-1 clear gen_count and go to WAIT. Takes NCELLS clks, fits in one blank line.
//   WAIT -> RENDER when counter_y==0.
//   SEED entered from reset proceeds regardless of counter_y; it then goes to WAIT, or to RENDER if counter_y==0.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk in every state (never all-zero).
//  Commit and nxt writes occur only in RENDER; in_prefetch during SEED/WAIT still drives the pixel pipe.
//  Reset mid-SEED restarts seeding from idx 0. Reset mid-line blanks output within LEAD clks.
//  freeze held: picture static, gen_count constant. freeze changes take effect at next line end or blank.
// TESTING
//  1 rst held 3 clks -> vga_rgb=0, gen_count=0; after release SEED completes in 320 clks, state WAIT.
//  2 Latency: seed_mode=0, rule=90, frame line 0: first FG pixel at prefetch_x=640.
//    -> vga_rgb=8'hFC for exactly 4 clks starting 16 clks after x=640 presented; 0 at x=0+16 / blank.
//  3 rule=90 single seed -> lines 0-3: cell 160 only; lines 4-7: cells 159,161; lines 8-11: 158,162;
//    gen_count=1 after line 3 end.
//  4 Wrap: rule=16 (shift right), seed_mode=0 -> live cell at 160+g on generation g;
//    generation 160 shows cell 0 only (lines 640-643).
//  5 freeze=1 raised at line 100 -> cur unchanged, gen_count holds at 25, no reseed at blank; release resumes.
//  6 seed_mode=1 from reset -> cur[0..15] equal first 16 lfsr[0] bits from 16'hACE1; repeatable across runs.

Source files
------------

// File: rtl/ca_line_renderer.sv
// Elementary cellular-automaton pixel source behind the VGA sync generator; one generation per cell-row.
// Latency: column x shows on vga_rgb exactly LEAD clks after the clk that presents prefetch_x = x.
// Backpressure: none; a free-running pixel stream that consumes one prefetch column per clk.
//
// Ports: clk/rst (sync, active-high); in_prefetch, prefetch_x, counter_y from the sync generator;
//   rule (latched on reseed), seed_mode (0 = centre cell, 1 = LFSR row), freeze (hold generation);
//   vga_rgb RGB332 pixel (0 when blanked), gen_count generations committed since last seed.
module ca_line_renderer #(
  parameter int         H_VISIBLE  = 1280,
  parameter int         V_VISIBLE  = 1024,
  parameter int         CELL_SHIFT = 2,
  parameter int         LEAD       = 16,
  parameter logic [7:0] FG_COLOR   = 8'hFC,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_prefetch,
  input  logic [10:0] prefetch_x,
  input  logic [10:0] counter_y,
  input  logic [7:0]  rule,
  input  logic        seed_mode,
  input  logic        freeze,
  output logic [7:0]  vga_rgb,
  output logic [15:0] gen_count
);

  localparam int          NCELLS  = H_VISIBLE >> CELL_SHIFT;
  localparam int          IW      = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [10:0] Y_BLANK = 11'(V_VISIBLE);

  typedef enum logic [1:0] {ST_SEED, ST_WAIT, ST_RENDER} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       seed_idx_q, seed_idx_d;
  logic [NCELLS-1:0]   cur_q, cur_d;
  logic [NCELLS-1:0]   nxt_q, nxt_d;
  logic [7:0]          rule_q, rule_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         gen_q, gen_d;
  logic [7:0]          rgb_q, rgb_d;
  logic [LEAD-2:0]     pix_pipe_q, vis_pipe_q;
  logic                prev_vis_q;

  logic [10:0]         col_c;
  logic [IW-1:0]       c_sel, c_l, c_r;
  logic                pix_bit, new_bit, line_end, row_last, cell_start;
  logic [2:0]          nbhd;

  // Cell lookup for the presented column; out-of-range columns (blanking) are clamped to cell 0
  // and masked by in_prefetch, so the vectors are never indexed past their end.
  assign col_c      = prefetch_x >> CELL_SHIFT;
  assign c_sel      = (col_c < 11'(NCELLS)) ? col_c[IW-1:0] : '0;
  assign c_l        = (c_sel == '0) ? IW'(NCELLS - 1) : c_sel - 1'b1;
  assign c_r        = (c_sel == IW'(NCELLS - 1)) ? '0 : c_sel + 1'b1;
  assign pix_bit    = in_prefetch & cur_q[c_sel];
  assign nbhd       = {cur_q[c_l], cur_q[c_sel], cur_q[c_r]};
  assign new_bit    = rule_q[nbhd];
  assign cell_start = (prefetch_x[CELL_SHIFT-1:0] == '0);
  assign row_last   = &counter_y[CELL_SHIFT-1:0];
  assign line_end   = prev_vis_q & ~in_prefetch;

  // Fibonacci LFSR, taps 16,14,13,11, shifting right; bit 0 is the seed output.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign rgb_d = vis_pipe_q[LEAD-2] ? (pix_pipe_q[LEAD-2] ? FG_COLOR : BG_COLOR) : 8'h00;

  always_comb begin
    state_d    = state_q;
    seed_idx_d = seed_idx_q;
    rule_d     = rule_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    gen_d      = gen_q;
    unique case (state_q)
      ST_RENDER: begin
        if (in_prefetch && cell_start) nxt_d[c_sel] = new_bit;
        // Commit on the last pixel row of a cell-row: the whole line has rebuilt nxt from cur.
        if (line_end && row_last && !freeze) begin
          cur_d = nxt_q;
          if (gen_q != 16'hFFFF) gen_d = gen_q + 16'd1;
        end
        if (counter_y == Y_BLANK) begin
          if (freeze) begin
            state_d = ST_WAIT;
          end else begin
            state_d    = ST_SEED;
            rule_d     = rule;
            seed_idx_d = '0;
          end
        end
      end
      ST_SEED: begin
        cur_d[seed_idx_q] = seed_mode ? lfsr_q[0] : (seed_idx_q == IW'(NCELLS / 2));
        if (seed_idx_q == IW'(NCELLS - 1)) begin
          gen_d   = '0;
          state_d = (counter_y == '0) ? ST_RENDER : ST_WAIT;
        end else begin
          seed_idx_d = seed_idx_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (counter_y == '0) state_d = ST_RENDER;
      end
      default: state_d = ST_SEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEED;
      seed_idx_q <= '0;
      cur_q      <= '0;
      nxt_q      <= '0;
      rule_q     <= 8'd30;
      lfsr_q     <= 16'hACE1;
      gen_q      <= '0;
      rgb_q      <= '0;
      pix_pipe_q <= '0;
      vis_pipe_q <= '0;
      prev_vis_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      seed_idx_q    <= seed_idx_d;
      cur_q         <= cur_d;
      nxt_q         <= nxt_d;
      rule_q        <= rule_d;
      lfsr_q        <= lfsr_d;
      gen_q         <= gen_d;
      rgb_q         <= rgb_d;
      prev_vis_q    <= in_prefetch;
      pix_pipe_q[0] <= pix_bit;
      vis_pipe_q[0] <= in_prefetch;
      for (int i = 1; i < LEAD - 1; i++) begin
        pix_pipe_q[i] <= pix_pipe_q[i-1];
        vis_pipe_q[i] <= vis_pipe_q[i-1];
      end
    end
  end

  assign vga_rgb   = rgb_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_ca_line_renderer.sv
// Bench for ca_line_renderer on a reduced raster (64x48 visible, 16 cells, LEAD 16).
// Latency: expected pixels are delayed LEAD cycles through a queue before comparison.
// Backpressure: none; a free-running sync generator drives every cycle.
module tb_ca_line_renderer;

  localparam int H_VIS = 64;
  localparam int V_VIS = 48;
  localparam int H_TOT = 100;
  localparam int V_TOT = 50;
  localparam int CS    = 2;
  localparam int LEAD  = 16;
  localparam int NC    = H_VIS >> CS;
  localparam int M_RUN = 0, M_SEED = 1, M_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst, in_prefetch, seed_mode, freeze;
  logic [10:0] prefetch_x, counter_y;
  logic [7:0]  rule;
  logic [7:0]  vga_rgb;
  logic [15:0] gen_count;

  ca_line_renderer #(
    .H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS), .CELL_SHIFT(CS), .LEAD(LEAD),
    .FG_COLOR(8'hFC), .BG_COLOR(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .in_prefetch(in_prefetch), .prefetch_x(prefetch_x),
    .counter_y(counter_y), .rule(rule), .seed_mode(seed_mode), .freeze(freeze),
    .vga_rgb(vga_rgb), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int cx, cy, frame;
  int n_pass = 0, n_total = 0;

  // Behavioural model: whole-row generation step, event-driven phases, delayed pixel queue.
  logic [NC-1:0] m_cur;
  logic [7:0]    m_rule;
  logic [15:0]   m_lfsr;
  int            m_gen, m_phase, m_k;
  logic          m_prev_vis;
  logic [7:0]    pq[$];
  logic [7:0]    exp_rgb;
  logic [15:0]   exp_gen;
  logic          chk_en = 1'b0;

  function automatic logic [NC-1:0] ca_step(input logic [NC-1:0] c, input logic [7:0] r);
    logic [NC-1:0] o;
    for (int i = 0; i < NC; i++) begin
      int idx;
      idx  = 4 * int'(c[(i + NC - 1) % NC]) + 2 * int'(c[i]) + int'(c[(i + 1) % NC]);
      o[i] = r[idx];
    end
    return o;
  endfunction

  task automatic model_step();
    logic [7:0] px;
    if (rst) begin
      m_phase = M_SEED; m_k = 0; m_cur = '0; m_gen = 0; m_rule = 8'd30;
      m_lfsr = 16'hACE1; m_prev_vis = 1'b0; pq.delete();
      exp_rgb = 8'h00; exp_gen = 16'h0; chk_en = 1'b1;
      return;
    end
    px = (in_prefetch && m_cur[cx / (1 << CS)]) ? 8'hFC : 8'h00;
    case (m_phase)
      M_RUN: begin
        if (m_prev_vis && !in_prefetch && (cy % (1 << CS)) == (1 << CS) - 1 && !freeze) begin
          m_cur = ca_step(m_cur, m_rule);
          if (m_gen < 65535) m_gen++;
        end
        if (cy == V_VIS) begin
          if (freeze) m_phase = M_IDLE;
          else begin m_phase = M_SEED; m_rule = rule; m_k = 0; end
        end
      end
      M_SEED: begin
        m_cur[m_k] = seed_mode ? m_lfsr[0] : (m_k == NC / 2);
        if (m_k == NC - 1) begin
          m_gen = 0;
          m_phase = (cy == 0) ? M_RUN : M_IDLE;
        end else m_k++;
      end
      default: if (cy == 0) m_phase = M_RUN;
    endcase
    m_lfsr     = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    m_prev_vis = in_prefetch;
    pq.push_back(px);
    if (pq.size() > LEAD) void'(pq.pop_front());
    exp_rgb = (pq.size() == LEAD) ? pq[0] : 8'h00;
    exp_gen = 16'(m_gen);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (frame %0d y %0d x %0d)", nm, act, exp, frame, cy, cx);
  endtask

  // Literal expectation on the column presented LEAD cycles earlier on the current line.
  task automatic lit(input string nm, input int f, input int y, input int col, input logic [7:0] v);
    if (frame == f && cy == y && cx == col + LEAD) check(nm, 32'(vga_rgb), 32'(v));
  endtask

  task automatic lit_gen(input string nm, input int f, input int y, input int x, input int v);
    if (frame == f && cy == y && cx == x) check(nm, 32'(gen_count), 32'(v));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rgb_model", 32'(vga_rgb), 32'(exp_rgb));
      check("gen_model", 32'(gen_count), 32'(exp_gen));
      if (frame == 0 && cy == V_VIS && cx == 2) begin
        check("reset_rgb", 32'(vga_rgb), 32'h0);
        check("reset_gen", 32'(gen_count), 32'h0);
      end
      // Rule 30 (reset default), centre seed at cell 8.
      lit("f1_l0_col32", 1, 0, 32, 8'hFC);
      lit("f1_l0_col35", 1, 0, 35, 8'hFC);
      lit("f1_l0_col31", 1, 0, 31, 8'h00);
      lit("f1_l0_col36", 1, 0, 36, 8'h00);
      lit("f1_l0_col0",  1, 0, 0,  8'h00);
      lit("f1_l4_col28", 1, 4, 28, 8'hFC);
      lit("f1_l4_col24", 1, 4, 24, 8'h00);
      lit("f1_l4_col39", 1, 4, 39, 8'hFC);
      lit("f1_l4_col40", 1, 4, 40, 8'h00);
      lit_gen("f1_gen_l4", 1, 4, 0, 1);
      // Rule 90 latched at the blank before frame 2.
      lit("f2_l0_col32", 2, 0, 32, 8'hFC);
      lit("f2_l4_col32", 2, 4, 32, 8'h00);
      lit("f2_l4_col28", 2, 4, 28, 8'hFC);
      lit("f2_l4_col36", 2, 4, 36, 8'hFC);
      lit("f2_l8_col24", 2, 8, 24, 8'hFC);
      lit("f2_l8_col40", 2, 8, 40, 8'hFC);
      lit("f2_l8_col32", 2, 8, 32, 8'h00);
      lit_gen("f2_gen_l4", 2, 4, 0, 1);
      // Rule 16 shifts right; generation 8 wraps onto cell 0.
      lit("f3_l28_col60", 3, 28, 60, 8'hFC);
      lit("f3_l28_col63", 3, 28, 63, 8'hFC);
      lit("f3_l28_blank", 3, 28, 64, 8'h00);
      lit("f3_l32_col0",  3, 32, 0,  8'hFC);
      lit("f3_l32_col4",  3, 32, 4,  8'h00);
      lit_gen("f3_gen_blank", 3, V_VIS, 5, 12);
      lit_gen("f3_gen_reseed", 3, V_VIS + 1, 0, 0);
      // Freeze from frame 4 line 20 to frame 5 line 10.
      lit_gen("f4_gen_frozen", 4, 30, 0, 5);
      lit_gen("f5_gen_noreseed", 5, 9, 0, 5);
      lit_gen("f5_gen_resume", 5, 12, 0, 6);
      // LFSR seed after a mid-line reset: cells follow the bits of 16'hACE1.
      for (int f = 8; f <= 9; f++) begin
        lit("lfsr_cell0",  f, 8, 0,  8'hFC);
        lit("lfsr_cell1",  f, 8, 4,  8'h00);
        lit("lfsr_cell5",  f, 8, 20, 8'hFC);
        lit("lfsr_cell12", f, 8, 48, 8'h00);
        lit("lfsr_cell15", f, 8, 60, 8'hFC);
        if (frame == f && cy == 8 && cx == 0) check("model_seed", 32'(m_cur), 32'h0000ACE1);
      end
    end
  end

  initial begin
    rst = 1'b1; in_prefetch = 1'b0; prefetch_x = '0; counter_y = '0;
    rule = 8'd90; seed_mode = 1'b0; freeze = 1'b0;
    cx = 0; cy = V_VIS; frame = 0;
    while (!(frame == 9 && cy == 20)) begin
      rst = (frame == 0 && cy == V_VIS && cx < 3) ||
            (frame >= 8 && cy == 5 && cx >= 20 && cx < 23);
      prefetch_x  = 11'(cx);
      counter_y   = 11'(cy);
      in_prefetch = (cx < H_VIS) && (cy < V_VIS);
      if (frame == 6 || frame == 7) begin
        rule      = 8'($urandom);
        seed_mode = 1'($urandom);
        if ($urandom_range(0, 199) == 0) freeze = ~freeze;
      end else begin
        rule      = (frame <= 1) ? 8'd90 : (frame == 2) ? 8'd16 : 8'd30;
        seed_mode = (frame >= 8);
        freeze    = (frame == 4 && cy >= 20) || (frame == 5 && cy < 10);
      end
      @(posedge clk);
      model_step();
      #1;
      cx++;
      if (cx == H_TOT) begin
        cx = 0;
        cy++;
        if (cy == V_TOT) begin
          cy = 0;
          frame++;
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
